// File: rtl/lfo_param_controller.sv
// LFO parameter controller: two push buttons adjust either the LFO rate (Hz)
// or the modulation depth (ms), selected by SW[3:0]. A rate change launches a
// restoring divider that turns RATE_CONST / rate into an LFO period count;
// a depth change is scaled to samples. Held buttons auto-repeat.
module lfo_param_controller #(
  parameter int DATA_W         = 32,
  parameter int RATE_CONST     = 97656,
  parameter int FREQ_MIN       = 1,
  parameter int FREQ_MAX       = 10,
  parameter int FREQ_DEF       = 5,
  parameter int DEPTH_MIN      = 5,
  parameter int DEPTH_MAX      = 10,
  parameter int DEPTH_DEF      = 5,
  parameter int SAMPLES_PER_MS = 48,
  parameter int FREQ_SEL       = 6,
  parameter int DEPTH_SEL      = 7,
  parameter int EN_BIT         = 5,
  parameter int REPEAT_DLY     = 24000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              key3,
  input  logic              key2,
  input  logic [9:0]        SW,
  output logic [DATA_W-1:0] frequency,
  output logic [15:0]       depth_samples,
  output logic              disabled,
  output logic              busy,
  output logic              upd
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [DATA_W-1:0] DIVIDEND   = DATA_W'(RATE_CONST);
  localparam logic [DATA_W-1:0] FREQ_RESET = DATA_W'(RATE_CONST / FREQ_DEF);
  localparam logic [DATA_W-1:0] F_MIN      = DATA_W'(FREQ_MIN);
  localparam logic [DATA_W-1:0] F_MAX      = DATA_W'(FREQ_MAX);
  localparam logic [DATA_W-1:0] F_DEF      = DATA_W'(FREQ_DEF);
  localparam logic [DATA_W-1:0] F_ONE      = DATA_W'(1);
  localparam logic [15:0]       D_MIN      = 16'(DEPTH_MIN);
  localparam logic [15:0]       D_MAX      = 16'(DEPTH_MAX);
  localparam logic [15:0]       D_DEF      = 16'(DEPTH_DEF);
  localparam logic [15:0]       D_ONE      = 16'd1;
  localparam logic [15:0]       SPM        = 16'(SAMPLES_PER_MS);
  localparam logic [15:0]       DEPTH_RST  = 16'(DEPTH_DEF * SAMPLES_PER_MS);
  localparam logic [3:0]        SEL_RATE   = 4'(FREQ_SEL);
  localparam logic [3:0]        SEL_DEPTH  = 4'(DEPTH_SEL);
  localparam logic [31:0]       REP_LAST   = 32'(REPEAT_DLY - 1);
  localparam logic [CW-1:0]     LAST_BIT   = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Key vectors: index 1 = key3 (decrement), index 0 = key2 (increment)
  logic [1:0]        keys_s1_q, keys_s2_q, keys_p_q;
  logic [9:0]        sw_s1_q, sw_s2_q;
  logic [31:0]       rep_dec_q, rep_dec_d, rep_inc_q, rep_inc_d;
  logic [DATA_W-1:0] rate_q, rate_d;
  logic              start_q, start_d;
  logic [15:0]       depth_ms_q, depth_ms_d;
  logic              depth_chg_q, depth_chg_d;
  logic [15:0]       depth_samples_q, depth_samples_d;
  logic              disabled_q, disabled_d;
  logic              busy_q, busy_d;
  logic              upd_q, upd_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d, quot_q, quot_d, div_q, div_d, freq_q, freq_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              press_dec_s, press_inc_s, dec_s, inc_s;
  logic              sel_rate_s, sel_depth_s, fsm_upd_s;
  logic [DATA_W:0]   rem_shift_s, diff_s;
  logic              unused_sw_s;

  // Only the select code and enable bit have a function; other switches are spare
  assign unused_sw_s = ^sw_s2_q;

  // Two-flop synchronizers plus a history flop for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      keys_s1_q <= 2'b11;
      keys_s2_q <= 2'b11;
      keys_p_q  <= 2'b11;
      sw_s1_q   <= 10'd0;
      sw_s2_q   <= 10'd0;
    end else begin
      keys_s1_q <= {key3, key2};
      keys_s2_q <= keys_s1_q;
      keys_p_q  <= keys_s2_q;
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
    end
  end

  // Press detection, auto-repeat timers and parameter next-state
  always_comb begin
    rep_dec_d   = rep_dec_q;
    rep_inc_d   = rep_inc_q;
    rate_d      = rate_q;
    start_d     = 1'b0;
    depth_ms_d  = depth_ms_q;
    depth_chg_d = 1'b0;

    // A timer runs only while its key is held; each wrap is one repeat press
    if (keys_s2_q[1]) begin
      rep_dec_d = 32'd0;
    end else if (rep_dec_q == REP_LAST) begin
      rep_dec_d = 32'd0;
    end else begin
      rep_dec_d = rep_dec_q + 32'd1;
    end
    if (keys_s2_q[0]) begin
      rep_inc_d = 32'd0;
    end else if (rep_inc_q == REP_LAST) begin
      rep_inc_d = 32'd0;
    end else begin
      rep_inc_d = rep_inc_q + 32'd1;
    end

    press_dec_s = (keys_p_q[1] & ~keys_s2_q[1]) | (~keys_s2_q[1] & (rep_dec_q == REP_LAST));
    press_inc_s = (keys_p_q[0] & ~keys_s2_q[0]) | (~keys_s2_q[0] & (rep_inc_q == REP_LAST));
    // Simultaneous presses cancel each other
    dec_s = press_dec_s & ~press_inc_s;
    inc_s = press_inc_s & ~press_dec_s;

    sel_rate_s  = (sw_s2_q[3:0] == SEL_RATE);
    sel_depth_s = (sw_s2_q[3:0] == SEL_DEPTH);

    // Rate presses are dropped while a divide is pending or running
    if (sel_rate_s && !busy_q) begin
      if (inc_s && (rate_q < F_MAX)) begin
        rate_d  = rate_q + F_ONE;
        start_d = 1'b1;
      end else if (dec_s && (rate_q > F_MIN)) begin
        rate_d  = rate_q - F_ONE;
        start_d = 1'b1;
      end else begin
        rate_d  = rate_q;
      end
    end else if (sel_depth_s) begin
      if (inc_s && (depth_ms_q < D_MAX)) begin
        depth_ms_d  = depth_ms_q + D_ONE;
        depth_chg_d = 1'b1;
      end else if (dec_s && (depth_ms_q > D_MIN)) begin
        depth_ms_d  = depth_ms_q - D_ONE;
        depth_chg_d = 1'b1;
      end else begin
        depth_ms_d  = depth_ms_q;
      end
    end else begin
      rate_d     = rate_q;
      depth_ms_d = depth_ms_q;
    end
  end

  // Parameter registers and auto-repeat timers
  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_dec_q   <= 32'd0;
      rep_inc_q   <= 32'd0;
      rate_q      <= F_DEF;
      start_q     <= 1'b0;
      depth_ms_q  <= D_DEF;
      depth_chg_q <= 1'b0;
    end else begin
      rep_dec_q   <= rep_dec_d;
      rep_inc_q   <= rep_inc_d;
      rate_q      <= rate_d;
      start_q     <= start_d;
      depth_ms_q  <= depth_ms_d;
      depth_chg_q <= depth_chg_d;
    end
  end

  // Rate FSM next state and restoring divider datapath
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    freq_d      = freq_q;
    fsm_upd_s   = 1'b0;
    rem_shift_s = {rem_q, quot_q[DATA_W-1]};
    diff_s      = rem_shift_s - {1'b0, div_q};

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_DIV;
          rem_d   = '0;
          quot_d  = DIVIDEND;
          div_d   = rate_q;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // Borrow out of the trial subtraction means the divisor did not fit
        if (diff_s[DATA_W]) begin
          rem_d  = rem_shift_s[DATA_W-1:0];
          quot_d = {quot_q[DATA_W-2:0], 1'b0};
        end else begin
          rem_d  = diff_s[DATA_W-1:0];
          quot_d = {quot_q[DATA_W-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        freq_d    = quot_q;
        fsm_upd_s = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy already covers the cycle between the rate update and DIV entry
    busy_d          = start_d | (state_d != S_IDLE);
    upd_d           = fsm_upd_s | depth_chg_q;
    disabled_d      = ~sw_s2_q[EN_BIT];
    depth_samples_d = depth_chg_q ? 16'(depth_ms_q * SPM) : depth_samples_q;
  end

  // FSM state, divider registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      quot_q          <= '0;
      div_q           <= '0;
      cnt_q           <= '0;
      freq_q          <= FREQ_RESET;
      depth_samples_q <= DEPTH_RST;
      disabled_q      <= 1'b0;
      busy_q          <= 1'b0;
      upd_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      quot_q          <= quot_d;
      div_q           <= div_d;
      cnt_q           <= cnt_d;
      freq_q          <= freq_d;
      depth_samples_q <= depth_samples_d;
      disabled_q      <= disabled_d;
      busy_q          <= busy_d;
      upd_q           <= upd_d;
    end
  end

  assign frequency     = freq_q;
  assign depth_samples = depth_samples_q;
  assign disabled      = disabled_q;
  assign busy          = busy_q;
  assign upd           = upd_q;

endmodule

// File: tb/tb_lfo_param_controller.sv
// Self-checking bench for lfo_param_controller. A small model keeps the
// rate and depth settings and derives expected outputs arithmetically.
module tb_lfo_param_controller;

  localparam int DATA_W     = 32;
  localparam int RATE_CONST = 97656;
  localparam int REP        = 100;

  logic              CLK = 1'b0;
  logic              RST;
  logic              key3, key2;
  logic [9:0]        SW;
  logic [DATA_W-1:0] frequency;
  logic [15:0]       depth_samples;
  logic              disabled, busy, upd;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_total  = 0;
  int busy_total = 0;
  int m_rate, m_depth;

  lfo_param_controller #(.DATA_W(DATA_W), .RATE_CONST(RATE_CONST), .REPEAT_DLY(REP)) dut (
    .CLK(CLK), .RST(RST), .key3(key3), .key2(key2), .SW(SW),
    .frequency(frequency), .depth_samples(depth_samples),
    .disabled(disabled), .busy(busy), .upd(upd)
  );

  always #5 CLK = ~CLK;

  // Running totals of upd pulses and busy cycles, sampled mid-cycle
  always @(negedge CLK) begin
    if (upd === 1'b1) upd_total++;
    if (busy === 1'b1) busy_total++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_press(input bit inc, input int hold);
    if (inc) key2 = 1'b0; else key3 = 1'b0;
    tick(hold);
    key2 = 1'b1;
    key3 = 1'b1;
  endtask

  // Reference rule: code 6 moves rate within 1..10, code 7 moves depth within 5..10
  function automatic int model_step(input int code, input bit inc);
    if (code == 6) begin
      if (inc && m_rate < 10) begin m_rate++; return 1; end
      if (!inc && m_rate > 1) begin m_rate--; return 1; end
    end else if (code == 7) begin
      if (inc && m_depth < 10) begin m_depth++; return 1; end
      if (!inc && m_depth > 5) begin m_depth--; return 1; end
    end
    return 0;
  endfunction

  task automatic test_reset;
    RST = 1'b1; key2 = 1'b1; key3 = 1'b1; SW = 10'h026;
    tick(3);
    n_checks++; if (frequency !== 32'd19531) begin n_fail++; $display("FAIL reset_freq: got %0d expected 19531", frequency); end
    n_checks++; if (depth_samples !== 16'd240) begin n_fail++; $display("FAIL reset_depth: got %0d expected 240", depth_samples); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b expected 0", upd); end
    n_checks++; if (disabled !== 1'b0) begin n_fail++; $display("FAIL reset_disabled: got %b expected 0", disabled); end
    RST = 1'b0; m_rate = 5; m_depth = 5;
    tick(5);
    n_checks++; if (disabled !== 1'b0) begin n_fail++; $display("FAIL enabled_after_reset: got %b expected 0", disabled); end
  endtask

  task automatic test_rate_inc;
    int u0, b0, fchg, old_f;
    old_f = RATE_CONST / m_rate;
    u0 = upd_total; b0 = busy_total; fchg = 0;
    key2 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK); #1;
      if (fchg == 0 && frequency !== DATA_W'(old_f)) fchg = k;
      if (k == 10) key2 = 1'b1;
    end
    void'(model_step(6, 1'b1));
    n_checks++; if (fchg != 3 + DATA_W + 2) begin n_fail++; $display("FAIL inc_latency: got %0d expected %0d", fchg, 3 + DATA_W + 2); end
    n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL inc_freq: got %0d expected %0d", frequency, RATE_CONST / m_rate); end
    n_checks++; if (busy_total - b0 != 34) begin n_fail++; $display("FAIL inc_busy_cycles: got %0d expected 34", busy_total - b0); end
    n_checks++; if (upd_total - u0 != 1) begin n_fail++; $display("FAIL inc_upd_count: got %0d expected 1", upd_total - u0); end
  endtask

  task automatic test_rate_floor;
    int u0, chg;
    for (int i = 0; i < 9; i++) begin
      u0 = upd_total;
      do_press(1'b0, 5);
      tick(45);
      chg = model_step(6, 1'b0);
      n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL floor_freq[%0d]: got %0d expected %0d", i, frequency, RATE_CONST / m_rate); end
      n_checks++; if (upd_total - u0 != chg) begin n_fail++; $display("FAIL floor_upd[%0d]: got %0d expected %0d", i, upd_total - u0, chg); end
    end
    n_checks++; if (frequency !== 32'd97656) begin n_fail++; $display("FAIL floor_final: got %0d expected 97656", frequency); end
  endtask

  task automatic test_depth;
    int u0, dk, uk;
    logic [15:0] old_d;
    SW = 10'h027;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      u0 = upd_total; dk = 0; uk = 0; old_d = depth_samples;
      key2 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge CLK); #1;
        if (dk == 0 && depth_samples !== old_d) dk = k;
        if (uk == 0 && upd === 1'b1) uk = k;
        if (k == 5) key2 = 1'b1;
      end
      void'(model_step(7, 1'b1));
      n_checks++; if (depth_samples !== 16'(m_depth * 48)) begin n_fail++; $display("FAIL depth_val[%0d]: got %0d expected %0d", i, depth_samples, m_depth * 48); end
      n_checks++; if (dk != 4) begin n_fail++; $display("FAIL depth_latency[%0d]: got %0d expected 4", i, dk); end
      n_checks++; if (uk != 4) begin n_fail++; $display("FAIL depth_upd_cycle[%0d]: got %0d expected 4", i, uk); end
      n_checks++; if (upd_total - u0 != 1) begin n_fail++; $display("FAIL depth_upd_count[%0d]: got %0d expected 1", i, upd_total - u0); end
      n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL depth_freq_hold[%0d]: got %0d expected %0d", i, frequency, RATE_CONST / m_rate); end
      tick(10);
    end
  endtask

  task automatic test_back_to_back;
    int u0;
    SW = 10'h026;
    tick(4);
    u0 = upd_total;
    key2 = 1'b0; key3 = 1'b0;
    tick(8);
    key2 = 1'b1; key3 = 1'b1;
    tick(40);
    n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL cancel_freq: got %0d expected %0d", frequency, RATE_CONST / m_rate); end
    n_checks++; if (upd_total - u0 != 0) begin n_fail++; $display("FAIL cancel_upd: got %0d expected 0", upd_total - u0); end
    // Rate press, a second rate press while busy, then a depth press while busy
    u0 = upd_total;
    do_press(1'b1, 6);
    void'(model_step(6, 1'b1));
    tick(6);
    do_press(1'b1, 4);
    SW = 10'h027;
    tick(6);
    do_press(1'b1, 5);
    void'(model_step(7, 1'b1));
    tick(60);
    n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL busy_drop_freq: got %0d expected %0d", frequency, RATE_CONST / m_rate); end
    n_checks++; if (depth_samples !== 16'(m_depth * 48)) begin n_fail++; $display("FAIL busy_depth: got %0d expected %0d", depth_samples, m_depth * 48); end
    n_checks++; if (upd_total - u0 != 2) begin n_fail++; $display("FAIL busy_upd_count: got %0d expected 2", upd_total - u0); end
  endtask

  task automatic test_repeat;
    int u0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0; m_rate = 5; m_depth = 5;
    SW = 10'h026;
    tick(6);
    u0 = upd_total;
    key2 = 1'b0;
    tick(350);
    key2 = 1'b1;
    tick(60);
    // 350 held cycles with a 100-cycle repeat: the press plus three repeats
    for (int i = 0; i < 4; i++) void'(model_step(6, 1'b1));
    n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL repeat_freq: got %0d expected %0d", frequency, RATE_CONST / m_rate); end
    n_checks++; if (upd_total - u0 != 4) begin n_fail++; $display("FAIL repeat_upd_count: got %0d expected 4", upd_total - u0); end
  endtask

  task automatic test_reset_mid_div;
    int u0;
    u0 = upd_total;
    do_press(1'b1, 5);
    tick(10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_div_busy: got %b expected 1", busy); end
    RST = 1'b1;
    tick(1);
    n_checks++; if (frequency !== 32'd19531) begin n_fail++; $display("FAIL abort_freq: got %0d expected 19531", frequency); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    RST = 1'b0; m_rate = 5; m_depth = 5;
    tick(40);
    n_checks++; if (upd_total - u0 != 0) begin n_fail++; $display("FAIL abort_upd: got %0d expected 0", upd_total - u0); end
    n_checks++; if (frequency !== 32'd19531) begin n_fail++; $display("FAIL abort_freq_hold: got %0d expected 19531", frequency); end
    n_checks++; if (depth_samples !== 16'd240) begin n_fail++; $display("FAIL abort_depth: got %0d expected 240", depth_samples); end
    SW = 10'h006;
    tick(2);
    n_checks++; if (disabled !== 1'b0) begin n_fail++; $display("FAIL dis_early: got %b expected 0", disabled); end
    tick(1);
    n_checks++; if (disabled !== 1'b1) begin n_fail++; $display("FAIL dis_set: got %b expected 1", disabled); end
    SW = 10'h026;
    tick(3);
    n_checks++; if (disabled !== 1'b0) begin n_fail++; $display("FAIL dis_clear: got %b expected 0", disabled); end
  endtask

  task automatic test_random;
    int u0, code, hold, chg, pick;
    bit inc;
    for (int i = 0; i < 12; i++) begin
      pick = $urandom_range(0, 2);
      code = (pick == 0) ? 6 : ((pick == 1) ? 7 : 3);
      inc  = 1'($urandom_range(0, 1));
      hold = $urandom_range(2, 20);
      SW = 10'h020 | 10'(code);
      tick(4);
      u0 = upd_total;
      do_press(inc, hold);
      tick(60 - hold);
      chg = model_step(code, inc);
      n_checks++; if (frequency !== DATA_W'(RATE_CONST / m_rate)) begin n_fail++; $display("FAIL rand_freq[%0d]: got %0d expected %0d", i, frequency, RATE_CONST / m_rate); end
      n_checks++; if (depth_samples !== 16'(m_depth * 48)) begin n_fail++; $display("FAIL rand_depth[%0d]: got %0d expected %0d", i, depth_samples, m_depth * 48); end
      n_checks++; if (upd_total - u0 != chg) begin n_fail++; $display("FAIL rand_upd[%0d]: got %0d expected %0d", i, upd_total - u0, chg); end
    end
  endtask

  initial begin
    RST = 1'b1; key2 = 1'b1; key3 = 1'b1; SW = 10'h026;
    m_rate = 5; m_depth = 5;
    test_reset;
    test_rate_inc;
    test_rate_floor;
    test_depth;
    test_back_to_back;
    test_repeat;
    test_reset_mid_div;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
